// File: rtl/wb_arbiter_decoder_pkg.sv
// Shared types and constants for the two-master / four-slave Wishbone interconnect.
package wb_arbiter_decoder_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_ERR  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_e;

    localparam logic        RST_ENABLE    = 1'b1;
    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
    localparam logic        WRITE_DISABLE = 1'b0;

    localparam logic [3:0] DEF_S0_TAG = 4'h0;
    localparam logic [3:0] DEF_S1_TAG = 4'h1;
    localparam logic [3:0] DEF_S2_TAG = 4'h2;
    localparam logic [3:0] DEF_S3_TAG = 4'h3;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        we;
        logic [3:0]  sel;
        logic        stb;
        logic        cyc;
    } wb_req_t;

    function automatic logic [1:0] owner_grant(input owner_e owner);
        return (owner == OWN_M1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// Maps the top address nibble onto a slave index; lowest index wins if tags collide.
module wb_addr_decode
    import wb_arbiter_decoder_pkg::*;
#(
    parameter logic [3:0] S0_TAG = DEF_S0_TAG,
    parameter logic [3:0] S1_TAG = DEF_S1_TAG,
    parameter logic [3:0] S2_TAG = DEF_S2_TAG,
    parameter logic [3:0] S3_TAG = DEF_S3_TAG
) (
    input  logic [3:0] tag_i,
    output logic [1:0] idx_o,
    output logic       hit_o
);

    // NOTE: every output gets a default before the priority chain so no latch is inferred.
    always_comb begin
        idx_o = 2'd0;
        hit_o = 1'b0;
        if (tag_i == S0_TAG) begin
            idx_o = 2'd0;
            hit_o = 1'b1;
        end else if (tag_i == S1_TAG) begin
            idx_o = 2'd1;
            hit_o = 1'b1;
        end else if (tag_i == S2_TAG) begin
            idx_o = 2'd2;
            hit_o = 1'b1;
        end else if (tag_i == S3_TAG) begin
            idx_o = 2'd3;
            hit_o = 1'b1;
        end
    end

endmodule

// File: rtl/wb_arbiter_decoder.sv
// Round-robin arbiter, address decoder and response router between the data and
// instruction Wishbone masters and four slaves, with unmapped/timeout error responses.
module wb_arbiter_decoder
    import wb_arbiter_decoder_pkg::*;
#(
    parameter logic [3:0]  S0_TAG  = DEF_S0_TAG,
    parameter logic [3:0]  S1_TAG  = DEF_S1_TAG,
    parameter logic [3:0]  S2_TAG  = DEF_S2_TAG,
    parameter logic [3:0]  S3_TAG  = DEF_S3_TAG,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  m0_addr_i,
    input  logic [31:0]  m0_data_i,
    input  logic         m0_we_i,
    input  logic [3:0]   m0_sel_i,
    input  logic         m0_stb_i,
    input  logic         m0_cyc_i,
    output logic [31:0]  m0_data_o,
    output logic         m0_ack_o,
    input  logic [31:0]  m1_addr_i,
    input  logic [31:0]  m1_data_i,
    input  logic         m1_we_i,
    input  logic [3:0]   m1_sel_i,
    input  logic         m1_stb_i,
    input  logic         m1_cyc_i,
    output logic [31:0]  m1_data_o,
    output logic         m1_ack_o,
    output logic [31:0]  s_addr_o,
    output logic [31:0]  s_data_o,
    output logic         s_we_o,
    output logic [3:0]   s_sel_o,
    output logic [3:0]   s_stb_o,
    output logic [3:0]   s_cyc_o,
    input  logic [127:0] s_data_i,
    input  logic [3:0]   s_ack_i,
    output logic [1:0]   grant_o,
    output logic         bus_err_o
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    arb_state_e  state_q, state_d;
    owner_e      last_q, last_d;
    owner_e      win_owner;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        bus_err_q, bus_err_d;

    wb_req_t     m0_req, m1_req, win_req, own_req;
    logic        req0, req1;
    logic [1:0]  dec_idx;
    logic        dec_hit;
    logic        slave_ack, timeout_hit, forced_term;
    logic [31:0] slave_rdata;
    logic        own_ack;
    logic [31:0] own_rdata;

    assign m0_req = '{addr: m0_addr_i, data: m0_data_i, we: m0_we_i,
                      sel: m0_sel_i, stb: m0_stb_i, cyc: m0_cyc_i};
    assign m1_req = '{addr: m1_addr_i, data: m1_data_i, we: m1_we_i,
                      sel: m1_sel_i, stb: m1_stb_i, cyc: m1_cyc_i};

    assign req0 = m0_req.cyc & m0_req.stb;
    assign req1 = m1_req.cyc & m1_req.stb;

    // On contention the master that did not own the bus last goes first.
    always_comb begin
        win_owner = OWN_M0;
        if (req0 && req1) begin
            win_owner = (last_q == OWN_M1) ? OWN_M0 : OWN_M1;
        end else if (req1) begin
            win_owner = OWN_M1;
        end
    end

    assign win_req = (win_owner == OWN_M1) ? m1_req : m0_req;
    assign own_req = (last_q == OWN_M1) ? m1_req : m0_req;

    wb_addr_decode #(
        .S0_TAG (S0_TAG),
        .S1_TAG (S1_TAG),
        .S2_TAG (S2_TAG),
        .S3_TAG (S3_TAG)
    ) u_addr_decode (
        .tag_i (win_req.addr[31:28]),
        .idx_o (dec_idx),
        .hit_o (dec_hit)
    );

    assign slave_ack   = s_ack_i[idx_q];
    assign slave_rdata = s_data_i[{idx_q, 5'b0} +: 32];
    assign timeout_hit = (cnt_q == TIMEOUT_LAST);
    // A flush (cyc dropped) outranks a timeout; an ack outranks both.
    assign forced_term = timeout_hit & own_req.cyc & ~slave_ack;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        bus_err_d = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (req0 || req1) begin
                    last_d  = win_owner;
                    grant_d = owner_grant(win_owner);
                    idx_d   = dec_idx;
                    cnt_d   = 8'd0;
                    state_d = dec_hit ? ARB_BUSY : ARB_ERR;
                end
            end
            ARB_BUSY: begin
                if (slave_ack || !own_req.cyc) begin
                    state_d = ARB_IDLE;
                    grant_d = 2'b00;
                end else if (forced_term) begin
                    state_d   = ARB_IDLE;
                    grant_d   = 2'b00;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ARB_ERR: begin
                state_d   = ARB_IDLE;
                grant_d   = 2'b00;
                bus_err_d = 1'b1;
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // NOTE: state flops use non-blocking assignments; reset here is synchronous.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q   <= ARB_IDLE;
            last_q    <= OWN_M1;
            grant_q   <= 2'b00;
            idx_q     <= 2'd0;
            cnt_q     <= 8'd0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Bus outputs are gated by rst as well as state so a reset drops strobes at once.
    always_comb begin
        s_addr_o  = ZERO_WORD;
        s_data_o  = ZERO_WORD;
        s_we_o    = WRITE_DISABLE;
        s_sel_o   = 4'b0000;
        s_stb_o   = 4'b0000;
        s_cyc_o   = 4'b0000;
        own_ack   = 1'b0;
        own_rdata = ZERO_WORD;
        if (rst != RST_ENABLE) begin
            case (state_q)
                ARB_BUSY: begin
                    s_addr_o = own_req.addr;
                    s_data_o = own_req.data;
                    s_we_o   = own_req.we;
                    s_sel_o  = own_req.sel;
                    if (forced_term) begin
                        own_ack = 1'b1;
                    end else begin
                        s_stb_o[idx_q] = own_req.stb & own_req.cyc;
                        s_cyc_o[idx_q] = own_req.cyc;
                        own_ack        = slave_ack;
                        own_rdata      = slave_rdata;
                    end
                end
                ARB_ERR: begin
                    own_ack = own_req.cyc;
                end
                default: begin
                end
            endcase
        end
    end

    assign m0_ack_o  = (last_q == OWN_M0) & own_ack;
    assign m1_ack_o  = (last_q == OWN_M1) & own_ack;
    assign m0_data_o = (last_q == OWN_M0) ? own_rdata : ZERO_WORD;
    assign m1_data_o = (last_q == OWN_M1) ? own_rdata : ZERO_WORD;

    assign grant_o   = grant_q;
    assign bus_err_o = bus_err_q;

endmodule

// File: tb/tb_wb_arbiter_decoder.sv
// Directed bench for wb_arbiter_decoder: a decode/route vector table plus hand-built
// sequences for arbitration order, timeout, flush, error-without-cyc and reset.
module tb_wb_arbiter_decoder;

    localparam logic [127:0] S_RDATA_BG = {32'h3333_0003, 32'h2222_0002,
                                           32'h1111_0001, 32'h0F0F_0000};

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  m0_addr_i, m0_data_i, m1_addr_i, m1_data_i;
    logic         m0_we_i, m0_stb_i, m0_cyc_i, m1_we_i, m1_stb_i, m1_cyc_i;
    logic [3:0]   m0_sel_i, m1_sel_i;
    logic [31:0]  m0_data_o, m1_data_o;
    logic         m0_ack_o, m1_ack_o;
    logic [31:0]  s_addr_o, s_data_o;
    logic         s_we_o;
    logic [3:0]   s_sel_o, s_stb_o, s_cyc_o;
    logic [127:0] s_data_i;
    logic [3:0]   s_ack_i;
    logic [1:0]   grant_o;
    logic         bus_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_arbiter_decoder #(.TIMEOUT(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_addr_i (m0_addr_i),
        .m0_data_i (m0_data_i),
        .m0_we_i   (m0_we_i),
        .m0_sel_i  (m0_sel_i),
        .m0_stb_i  (m0_stb_i),
        .m0_cyc_i  (m0_cyc_i),
        .m0_data_o (m0_data_o),
        .m0_ack_o  (m0_ack_o),
        .m1_addr_i (m1_addr_i),
        .m1_data_i (m1_data_i),
        .m1_we_i   (m1_we_i),
        .m1_sel_i  (m1_sel_i),
        .m1_stb_i  (m1_stb_i),
        .m1_cyc_i  (m1_cyc_i),
        .m1_data_o (m1_data_o),
        .m1_ack_o  (m1_ack_o),
        .s_addr_o  (s_addr_o),
        .s_data_o  (s_data_o),
        .s_we_o    (s_we_o),
        .s_sel_o   (s_sel_o),
        .s_stb_o   (s_stb_o),
        .s_cyc_o   (s_cyc_o),
        .s_data_i  (s_data_i),
        .s_ack_i   (s_ack_i),
        .grant_o   (grant_o),
        .bus_err_o (bus_err_o)
    );

    typedef struct {
        string       name;
        bit          m;
        logic [31:0] addr;
        logic [1:0]  exp_grant;
        logic [3:0]  exp_stb;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic release_m(input bit m);
        if (!m) begin
            m0_addr_i = '0; m0_data_i = '0; m0_we_i = 1'b0;
            m0_sel_i  = '0; m0_stb_i  = 1'b0; m0_cyc_i = 1'b0;
        end else begin
            m1_addr_i = '0; m1_data_i = '0; m1_we_i = 1'b0;
            m1_sel_i  = '0; m1_stb_i  = 1'b0; m1_cyc_i = 1'b0;
        end
    endtask

    task automatic clear_all();
        release_m(1'b0);
        release_m(1'b1);
        s_ack_i  = 4'b0000;
        s_data_i = S_RDATA_BG;
    endtask

    task automatic drive_m(input bit m, input logic [31:0] addr, input logic we,
                           input logic [31:0] wdata);
        if (!m) begin
            m0_addr_i = addr; m0_data_i = wdata; m0_we_i = we;
            m0_sel_i  = 4'hF; m0_stb_i  = 1'b1;  m0_cyc_i = 1'b1;
        end else begin
            m1_addr_i = addr; m1_data_i = wdata; m1_we_i = we;
            m1_sel_i  = 4'hF; m1_stb_i  = 1'b1;  m1_cyc_i = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"v0 m0 s1",    1'b0, 32'h1000_0004, 2'b01, 4'b0010, 32'h1111_0001, 1'b0};
        vecs[1] = '{"v1 m1 s0",    1'b1, 32'h0000_0100, 2'b10, 4'b0001, 32'h0F0F_0000, 1'b0};
        vecs[2] = '{"v2 m0 s2",    1'b0, 32'h2000_0008, 2'b01, 4'b0100, 32'h2222_0002, 1'b0};
        vecs[3] = '{"v3 m1 s3",    1'b1, 32'h3000_000C, 2'b10, 4'b1000, 32'h3333_0003, 1'b0};
        vecs[4] = '{"v4 m0 unmap", 1'b0, 32'h7000_0000, 2'b01, 4'b0000, 32'h0000_0000, 1'b1};
        vecs[5] = '{"v5 m1 unmap", 1'b1, 32'hF000_0000, 2'b10, 4'b0000, 32'h0000_0000, 1'b1};

        // Reset with both masters requesting: everything must stay quiet.
        rst = 1'b1;
        clear_all();
        drive_m(1'b0, 32'h1000_0000, 1'b0, 32'h0);
        drive_m(1'b1, 32'h0000_0000, 1'b0, 32'h0);
        step();
        step();
        #1;
        check("rst grant", grant_o, 2'b00);
        check("rst s_stb", s_stb_o, 4'b0000);
        check("rst s_cyc", s_cyc_o, 4'b0000);
        check("rst s_addr", s_addr_o, 32'h0);
        check("rst m0_ack", m0_ack_o, 1'b0);
        check("rst bus_err", bus_err_o, 1'b0);
        step();
        rst = 1'b0;
        clear_all();

        // Decode / routing table: one transfer per vector from IDLE.
        for (int i = 0; i < 6; i++) begin
            step();
            drive_m(vecs[i].m, vecs[i].addr, 1'b0, 32'h0);
            #1;
            check({vecs[i].name, " idle grant"}, grant_o, 2'b00);
            check({vecs[i].name, " idle stb"}, s_stb_o, 4'b0000);
            step();
            s_ack_i = vecs[i].exp_stb;
            #1;
            check({vecs[i].name, " grant"}, grant_o, vecs[i].exp_grant);
            check({vecs[i].name, " stb"}, s_stb_o, vecs[i].exp_stb);
            check({vecs[i].name, " cyc"}, s_cyc_o, vecs[i].exp_stb);
            check({vecs[i].name, " own ack"}, vecs[i].m ? m1_ack_o : m0_ack_o, 1'b1);
            check({vecs[i].name, " own data"}, vecs[i].m ? m1_data_o : m0_data_o, vecs[i].exp_data);
            check({vecs[i].name, " other ack"}, vecs[i].m ? m0_ack_o : m1_ack_o, 1'b0);
            if (vecs[i].exp_stb != 4'b0000)
                check({vecs[i].name, " s_addr"}, s_addr_o, vecs[i].addr);
            step();
            clear_all();
            #1;
            check({vecs[i].name, " end grant"}, grant_o, 2'b00);
            check({vecs[i].name, " bus_err"}, bus_err_o, vecs[i].exp_err);
        end

        // M0 read of S1, ack two cycles after strobe.
        step();
        drive_m(1'b0, 32'h1000_0004, 1'b0, 32'h0);
        #1;
        check("A idle stb", s_stb_o, 4'b0000);
        step();
        #1;
        check("A N+1 stb", s_stb_o, 4'b0010);
        check("A N+1 grant", grant_o, 2'b01);
        check("A N+1 ack", m0_ack_o, 1'b0);
        step();
        #1;
        check("A N+2 stall ack", m0_ack_o, 1'b0);
        step();
        s_ack_i = 4'b0010;
        s_data_i[63:32] = 32'hA5A5_0001;
        #1;
        check("A ack", m0_ack_o, 1'b1);
        check("A data", m0_data_o, 32'hA5A5_0001);
        step();
        clear_all();
        #1;
        check("A release grant", grant_o, 2'b00);
        check("A no err", bus_err_o, 1'b0);

        // Simultaneous requests after reset: M0 first, then M1.
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive_m(1'b0, 32'h1000_0000, 1'b0, 32'h0);
        drive_m(1'b1, 32'h0000_0040, 1'b0, 32'h0);
        #1;
        check("B idle grant", grant_o, 2'b00);
        step();
        #1;
        check("B first grant", grant_o, 2'b01);
        check("B first stb", s_stb_o, 4'b0010);
        s_ack_i = 4'b0010;
        #1;
        check("B m0 ack", m0_ack_o, 1'b1);
        check("B m1 stalled", m1_ack_o, 1'b0);
        step();
        s_ack_i = 4'b0000;
        release_m(1'b0);
        #1;
        check("B gap grant", grant_o, 2'b00);
        check("B gap stb", s_stb_o, 4'b0000);
        step();
        #1;
        check("B second grant", grant_o, 2'b10);
        check("B second stb", s_stb_o, 4'b0001);
        check("B second addr", s_addr_o, 32'h0000_0040);
        s_ack_i = 4'b0001;
        #1;
        check("B m1 ack", m1_ack_o, 1'b1);
        check("B m1 data", m1_data_o, 32'h0F0F_0000);
        step();
        clear_all();

        // M0 write to S2 that never acks; TIMEOUT = 8.
        step();
        drive_m(1'b0, 32'h2000_0010, 1'b1, 32'hDEAD_BEEF);
        step();
        #1;
        check("C wdata", s_data_o, 32'hDEAD_BEEF);
        check("C we", s_we_o, 1'b1);
        for (int c = 1; c <= 7; c++) begin
            check($sformatf("C busy%0d stb", c), s_stb_o, 4'b0100);
            check($sformatf("C busy%0d ack", c), m0_ack_o, 1'b0);
            step();
            #1;
        end
        check("C forced ack", m0_ack_o, 1'b1);
        check("C forced data", m0_data_o, 32'h0);
        check("C forced stb", s_stb_o, 4'b0000);
        check("C forced cyc", s_cyc_o, 4'b0000);
        check("C err not yet", bus_err_o, 1'b0);
        step();
        clear_all();
        #1;
        check("C bus_err", bus_err_o, 1'b1);
        check("C grant", grant_o, 2'b00);
        check("C ack gone", m0_ack_o, 1'b0);
        step();
        #1;
        check("C err one pulse", bus_err_o, 1'b0);

        // M1 to S0 flushes at BUSY cycle 2; S0 acks late.
        step();
        drive_m(1'b1, 32'h0000_0010, 1'b0, 32'h0);
        step();
        #1;
        check("D busy1 stb", s_stb_o, 4'b0001);
        check("D grant", grant_o, 2'b10);
        step();
        m1_cyc_i = 1'b0;
        #1;
        check("D flush stb", s_stb_o, 4'b0000);
        check("D flush cyc", s_cyc_o, 4'b0000);
        check("D flush ack", m1_ack_o, 1'b0);
        step();
        s_ack_i = 4'b0001;
        #1;
        check("D late ack ignored", m1_ack_o, 1'b0);
        check("D idle grant", grant_o, 2'b00);
        check("D no err", bus_err_o, 1'b0);
        step();
        clear_all();
        #1;
        check("D still no err", bus_err_o, 1'b0);

        // Unmapped access where M1 drops cyc during ERR.
        step();
        drive_m(1'b1, 32'h7000_0000, 1'b0, 32'h0);
        step();
        release_m(1'b1);
        #1;
        check("E err grant", grant_o, 2'b10);
        check("E no ack", m1_ack_o, 1'b0);
        check("E no stb", s_stb_o, 4'b0000);
        step();
        #1;
        check("E bus_err", bus_err_o, 1'b1);

        // Reset during an M0 transfer with M1 waiting.
        step();
        drive_m(1'b0, 32'h1000_0020, 1'b0, 32'h0);
        step();
        drive_m(1'b1, 32'h0000_0080, 1'b0, 32'h0);
        #1;
        check("F busy grant", grant_o, 2'b01);
        check("F busy stb", s_stb_o, 4'b0010);
        step();
        #1;
        check("F m1 waits", m1_ack_o, 1'b0);
        check("F still m0", grant_o, 2'b01);
        rst = 1'b1;
        #1;
        check("F rst stb now", s_stb_o, 4'b0000);
        check("F rst cyc now", s_cyc_o, 4'b0000);
        step();
        rst = 1'b0;
        release_m(1'b0);
        #1;
        check("F after rst grant", grant_o, 2'b00);
        check("F after rst stb", s_stb_o, 4'b0000);
        check("F after rst addr", s_addr_o, 32'h0);
        step();
        #1;
        check("F m1 granted", grant_o, 2'b10);
        check("F m1 stb", s_stb_o, 4'b0001);
        s_ack_i = 4'b0001;
        #1;
        check("F m1 ack", m1_ack_o, 1'b1);
        step();
        clear_all();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arbiter_decoder.md
Name: wb_arbiter_decoder

Overview:
- Shared Wishbone interconnect between the two CPU-side Wishbone bus interfaces (M0 = data bus, M1 = instruction bus) and four slaves (S0 ROM, S1 RAM, S2 UART, S3 GPIO).
- Performs round-robin arbitration, address-nibble decoding and response routing.
- Generates an internal error response for unmapped addresses and for slaves that never acknowledge.

Parameters:
- S0_TAG, 4'h0, addr[31:28] value selecting S0
- S1_TAG, 4'h1, addr[31:28] value selecting S1
- S2_TAG, 4'h2, addr[31:28] value selecting S2
- S3_TAG, 4'h3, addr[31:28] value selecting S3
- TIMEOUT, 255, cycles in BUSY without ack before a forced error response (range 2..255)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- m0_addr_i / m1_addr_i  in  32  master address
- m0_data_i / m1_data_i  in  32  master write data
- m0_we_i / m1_we_i  in  1  write enable
- m0_sel_i / m1_sel_i  in  4  byte select
- m0_stb_i, m0_cyc_i / m1_stb_i, m1_cyc_i  in  1  strobe, cycle
- m0_data_o / m1_data_o  out  32  read data to master
- m0_ack_o / m1_ack_o  out  1  acknowledge to master
- s_addr_o  out  32  shared slave address
- s_data_o  out  32  shared slave write data
- s_we_o  out  1  shared write enable
- s_sel_o  out  4  shared byte select
- s_stb_o  out  4  per-slave strobe, bit n = Sn
- s_cyc_o  out  4  per-slave cycle, bit n = Sn
- s_data_i  in  128  slave read data, Sn at [32n+31:32n]
- s_ack_i  in  4  per-slave ack
- grant_o  out  2  one-hot current owner: bit0 = M0, bit1 = M1, 00 = none
- bus_err_o  out  1  one-cycle pulse on unmapped or timeout termination

Behaviour:
- Reset: state IDLE, grant_o = 00, last-owner register = M1, timeout counter = 0, bus_err_o = 0.
- Outputs while rst is high or in IDLE: all s_* = 0, m*_ack_o = 0, m*_data_o = 0.
- Request: master requests when its cyc_i & stb_i = 1.
- States: IDLE, BUSY, ERR.
- IDLE arbitration:
  - One requester: grant it.
  - Both requesting: grant the master that is not the last owner.
  - Owner and last-owner register update at the edge.
  - Decode addr[31:28] of the winning master at that same edge. Match -> BUSY with latched slave index. No match -> ERR.
- Latency: a request at cycle N gives slave stb/cyc at N+1. No bus activity occurs in IDLE.
- BUSY:
  - s_addr/data/we/sel driven combinationally from the owner master's inputs.
  - s_stb_o/s_cyc_o bit[idx] = owner stb/cyc; all other bits 0.
  - Owner m_ack_o = s_ack_i[idx] and m_data_o = s_data_i[idx] (combinational). Non-owner ack = 0, data = 0.
- BUSY exits:
  - ack -> IDLE at that edge; ownership released. At least one IDLE cycle always separates transfers.
  - Owner drops cyc without ack (flush abort) -> IDLE. Slave stb/cyc fall in that same cycle (combinational). bus_err_o is not asserted. A late slave ack is ignored.
  - Counter reaches TIMEOUT-1 without ack -> forced termination: owner ack = 1, data = 0, slave stb/cyc = 0 that cycle, bus_err_o pulses next cycle, -> IDLE.
  - The counter clears on entering BUSY.
- ERR (1 cycle): no slave strobed, owner ack = 1, data = 0, bus_err_o = 1 next cycle, -> IDLE.
  - If the owner has already dropped cyc, no ack is given and bus_err_o is still asserted.
- Simultaneous events:
  - Ack and cyc drop in the same cycle: treat as ack.
  - Ack and timeout in the same cycle: ack wins, no error.
- A request arriving while the other master is BUSY waits. That master's bus interface keeps stalling; no requests are dropped.
- Reset mid-transfer: everything returns to IDLE on the next edge; slave stb falls immediately (outputs gated by state).
- bus_err_o is registered; grant_o is registered.

Decomposition:
- defines.v gains the constants ARB_IDLE, ARB_BUSY, ARB_ERR (2-bit) and the default slave tags. Reuse RstEnable, ZeroWord, WriteDisable.
- One sub-module, wb_addr_decode: combinational; addr[31:28] plus tags -> 2-bit index and hit flag.

Test Plan:
- M0 read addr 0x1000_0004; S1 acks 2 cycles after stb with 0xA5A5_0001 -> s_stb_o = 0010 at N+1; m0_ack_o = 1 with m0_data_o = 0xA5A5_0001; grant_o returns to 00.
- M0 and M1 request in the same cycle after reset -> M0 granted first; M1 granted on the second IDLE after M0's ack; grant_o sequence 01, 00, 10.
- M1 read addr 0x7000_0000 (unmapped) -> no s_stb_o bit set; m1_ack_o = 1 with data 0 one cycle after grant; bus_err_o pulses once.
- M0 write to S2 with S2 never acking, TIMEOUT = 8 -> forced m0_ack_o on the 8th BUSY cycle; s_stb_o = 0000 that cycle; bus_err_o = 1 the next cycle.
- M1 in BUSY to S0 drops cyc at BUSY cycle 2 (flush), S0 acks one cycle later -> s_stb_o = 0000 immediately; state IDLE; m1_ack_o stays 0; no bus_err_o.
- rst asserted during M0 BUSY -> next cycle grant_o = 00, all s_* = 0, and a pending M1 request is granted after rst is released.
